// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder: handshaked Morse symbol stream to buffered ASCII characters
// sym_valid/sym/sym_ready : symbol input (01 dot, 11 dash, 00 letter gap, 10 word gap)
// char_data/char_valid/char_ready : show-ahead output FIFO head, popped when both valid and ready
// err : one-cycle pulse when the character just pushed was an invalid code
// elem_count : saturating count of dots/dashes since the last word gap
module morse_stream_decoder #(
  parameter int MAX_LEN    = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_valid,
  input  logic [1:0]       sym,
  output logic             sym_ready,
  output logic [7:0]       char_data,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             err,
  output logic [CNT_W-1:0] elem_count
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [LW-1:0]      len;
  logic [MAX_LEN-1:0] code;
  logic               ovl, last_sp;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]      wp, rp;
  logic [CW-1:0]      cnt;
  logic               acc, el, gap, has, pop;
  logic [1:0]         n_push;
  logic [7:0]         dec, d0;

  // Key is {len, code} with the earliest element in the most significant used bit.
  function automatic logic [7:0] lookup(input logic [LW-1:0] l, input logic [MAX_LEN-1:0] c);
    if (l > LW'(5)) return 8'h3F;
    case ({l[2:0], c[4:0]})
      {3'd1, 5'b00000}: return 8'h45;
      {3'd1, 5'b00001}: return 8'h54;
      {3'd2, 5'b00001}: return 8'h41;
      {3'd2, 5'b00000}: return 8'h49;
      {3'd2, 5'b00011}: return 8'h4D;
      {3'd2, 5'b00010}: return 8'h4E;
      {3'd3, 5'b00100}: return 8'h44;
      {3'd3, 5'b00110}: return 8'h47;
      {3'd3, 5'b00101}: return 8'h4B;
      {3'd3, 5'b00111}: return 8'h4F;
      {3'd3, 5'b00010}: return 8'h52;
      {3'd3, 5'b00000}: return 8'h53;
      {3'd3, 5'b00001}: return 8'h55;
      {3'd3, 5'b00011}: return 8'h57;
      {3'd4, 5'b01000}: return 8'h42;
      {3'd4, 5'b01010}: return 8'h43;
      {3'd4, 5'b00010}: return 8'h46;
      {3'd4, 5'b00000}: return 8'h48;
      {3'd4, 5'b00111}: return 8'h4A;
      {3'd4, 5'b00100}: return 8'h4C;
      {3'd4, 5'b00110}: return 8'h50;
      {3'd4, 5'b01101}: return 8'h51;
      {3'd4, 5'b00001}: return 8'h56;
      {3'd4, 5'b01001}: return 8'h58;
      {3'd4, 5'b01011}: return 8'h59;
      {3'd4, 5'b01100}: return 8'h5A;
      {3'd5, 5'b01111}: return 8'h31;
      {3'd5, 5'b00111}: return 8'h32;
      {3'd5, 5'b00011}: return 8'h33;
      {3'd5, 5'b00001}: return 8'h34;
      {3'd5, 5'b00000}: return 8'h35;
      {3'd5, 5'b10000}: return 8'h36;
      {3'd5, 5'b11000}: return 8'h37;
      {3'd5, 5'b11100}: return 8'h38;
      {3'd5, 5'b11110}: return 8'h39;
      {3'd5, 5'b11111}: return 8'h30;
      default:          return 8'h3F;
    endcase
  endfunction

  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW+1:0] t;
    t = {2'b00, p} + (PW+2)'(n);
    return t >= (PW+2)'(FIFO_DEPTH) ? PW'(t - (PW+2)'(FIFO_DEPTH)) : PW'(t);
  endfunction

  // Ready only with room for two pushes, so a word gap can never overflow the FIFO.
  assign sym_ready  = cnt <= CW'(FIFO_DEPTH - 2);
  assign char_valid = cnt != '0;
  assign char_data  = char_valid ? mem[rp] : 8'h00;

  always_comb begin
    acc    = sym_valid && sym_ready;
    el     = acc && sym[0];
    gap    = acc && !sym[0];
    has    = len != '0;
    pop    = char_ready && char_valid;
    dec    = ovl ? 8'h3F : lookup(len, code);
    d0     = has ? dec : 8'h20;
    n_push = !gap ? 2'd0 : has ? (sym[1] ? 2'd2 : 2'd1) : (sym[1] && !last_sp) ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= '0;
      code       <= '0;
      ovl        <= 1'b0;
      last_sp    <= 1'b1;
      err        <= 1'b0;
      elem_count <= '0;
      cnt        <= '0;
      wp         <= '0;
      rp         <= '0;
    end else begin
      if (el && len == LW'(MAX_LEN)) ovl <= 1'b1;
      else if (el) begin
        code <= {code[MAX_LEN-2:0], sym[1]};
        len  <= len + LW'(1);
      end
      if (gap) begin
        len  <= '0;
        code <= '0;
        ovl  <= 1'b0;
        if (has || sym[1]) last_sp <= sym[1];
      end
      err <= gap && has && dec == 8'h3F;
      if (gap && sym[1]) elem_count <= '0;
      else if (el && !(&elem_count)) elem_count <= elem_count + CNT_W'(1);
      cnt <= cnt + CW'(n_push) - CW'(pop);
      wp  <= adv(wp, n_push);
      if (pop) rp <= adv(rp, 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wp] <= d0;
    if (n_push == 2'd2) mem[adv(wp, 2'd1)] <= 8'h20;
  end
endmodule
